hdmi_tx_init_sequencer: RTL and testbench
=========================================

// Module: hdmi_tx_init_sequencer
// PURPOSE
//  Controller that configures the HDMI transmitter over I2C. It sits between the top level and the
//  I2C byte-write master. After reset it waits out the transmitter power-up time, then issues a
//  fixed table of register writes over a req/ack handshake, retrying each write on NACK.
//  A hot-plug interrupt (HDMI_TX_INT) re-runs the whole table so the transmitter is reconfigured
//  after a cable (re)connect.
// PARAMETERS
//  DEV_ADDR       8'h72      8-bit I2C write address of the transmitter
//  TABLE_LEN      12         number of entries in the internal write table (fixed at 12, see below)
//  WAIT_CYCLES    5_000_000  power-up / restart wait, in clock_25 cycles (200 ms); must be >=1
//  RETRY_GAP      2_500      idle cycles between a NACK and the re-issue of the same write; >=1
//  MAX_RETRIES    3          re-issues allowed per entry after the first NACK
//  INT_ACTIVE_LOW 1          1: interrupt asserts low; 0: interrupt asserts high
// PORTS
//  clock_25      in   1  system clock, 25 MHz
//  reset         in   1  synchronous, active-high reset
//  interrupt     in   1  HDMI_TX_INT from transmitter, asynchronous
//  wr_req        out  1  write request to I2C master
//  wr_dev_addr   out  8  device address, = DEV_ADDR
//  wr_reg_addr   out  8  register address of current entry
//  wr_data       out  8  data byte of current entry
//  wr_ack        in   1  1-cycle pulse: write completed, slave ACKed
//  wr_nack       in   1  1-cycle pulse: write failed, slave NACKed
//  busy          out  1  high whenever the FSM is not in DONE or ERROR
//  config_done   out  1  high in DONE: full table written
//  config_error  out  1  high in ERROR: an entry exhausted its retries
//  entry_index   out  4  index of the entry being or last written
// BEHAVIOUR
//  Table, idx: {reg,data}:
//   0:{41,10}  1:{98,03}  2:{9A,E0}  3:{9C,30}  4:{9D,61}  5:{A2,A4}
//   6:{A3,A4}  7:{E0,D0}  8:{F9,00}  9:{15,00}  10:{16,30}  11:{AF,06}
//  Reset values: wr_req=0, wr_reg_addr=0, wr_data=0, busy=1, config_done=0, config_error=0,
//   entry_index=0. Reset enters WAIT. Reset asserted mid-transaction returns to WAIT; any later
//   ack/nack from the master is ignored.
//  interrupt passes through a 2-FF synchroniser. An event is an assertion edge (falling edge when
//   INT_ACTIVE_LOW=1). An event raises a sticky pending flag.
//  FSM states:
//   WAIT:  counter counts WAIT_CYCLES cycles, then -> ISSUE with idx=0, retry count=0. Pending is
//          cleared on entry to WAIT.
//   ISSUE: wr_req=1; reg/data come from table[idx]. Outputs stay stable until the response.
//          wr_req is high in the first ISSUE cycle. After reset, wr_req first goes high on
//          cycle WAIT_CYCLES+1.
//   ISSUE, wr_ack sampled: wr_req drops next cycle.
//     If pending -> WAIT. Else if idx==TABLE_LEN-1 -> DONE. Else idx+1, retries=0 -> ISSUE.
//     The next entry's wr_req is high 1 cycle after the drop, so there is exactly 1 idle cycle.
//   ISSUE, wr_nack sampled (also when ack and nack are high together): wr_req drops.
//     If pending -> WAIT. Else if retries==MAX_RETRIES -> ERROR. Else retries+1 -> GAP.
//   GAP:   counts RETRY_GAP cycles, then -> ISSUE with the same idx.
//   DONE:  config_done=1, busy=0. A pending event -> WAIT (full restart).
//   ERROR: config_error=1, busy=0. Sticky. Leaves only on reset or a pending event -> WAIT.
//  Interrupt events never abort a transaction in flight. The restart takes effect at the next
//   ack/nack, or immediately in WAIT/GAP/DONE/ERROR. An event during WAIT re-arms nothing
//   (pending is cleared on WAIT entry), so WAIT is not extended.
//  wr_ack or wr_nack while wr_req=0: ignored.
//  entry_index = idx. config_done and config_error are never high together.
// TESTING (bench uses WAIT_CYCLES=10, RETRY_GAP=4, MAX_RETRIES=3)
//  1 Release reset; the model acks each req 5 cycles after it rises.
//    -> first req at cycle 11 with reg=41, data=10. Then 12 writes in table order, 1 idle cycle
//       between them. config_done=1 after the 12th ack (reg AF, data 06).
//  2 NACK entry 3 twice, then ACK.
//    -> reg 9C re-issued 4 cycles after each nack, data stable. Completes; config_done=1,
//       config_error=0.
//  3 NACK entry 5 four times.
//    -> exactly 4 requests with reg A2. Then config_error=1, busy=0, entry_index=5, and no
//       further req.
//  4 In DONE, pulse interrupt low for 3 cycles.
//    -> config_done drops within 4 cycles, a 10-cycle wait follows, then the table re-runs
//       from reg 41.
//  5 Assert interrupt while req for entry 7 is pending ack.
//    -> req stays high until the ack. Then WAIT, then restart at idx 0 without writing entry 8.
//  6 Assert reset for 1 cycle while wr_req=1 at entry 4.
//    -> next cycle wr_req=0, entry_index=0, busy=1. A stale ack is ignored. Restart from reg 41.

Source files
------------

// File: rtl/hdmi_tx_init_sequencer.sv
// Power-up and hot-plug configuration sequencer for the HDMI transmitter.
// Streams a fixed register table to an I2C byte-write master and retries NACKed writes.
module hdmi_tx_init_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h72,
    parameter int         TABLE_LEN      = 12,
    parameter int         WAIT_CYCLES    = 5_000_000,
    parameter int         RETRY_GAP      = 2_500,
    parameter int         MAX_RETRIES    = 3,
    parameter bit         INT_ACTIVE_LOW = 1'b1
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       interrupt,
    output logic       wr_req,
    output logic [7:0] wr_dev_addr,
    output logic [7:0] wr_reg_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    input  logic       wr_nack,
    output logic       busy,
    output logic       config_done,
    output logic       config_error,
    output logic [3:0] entry_index,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_ISSUE = 3'd1,
        S_NEXT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [31:0] WAIT_LAST = 32'(WAIT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(RETRY_GAP - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);
    localparam logic [3:0]  LAST_IDX  = 4'(TABLE_LEN - 1);
    localparam logic        INT_IDLE  = INT_ACTIVE_LOW;

    state_t      state;
    logic [31:0] cnt;
    logic [3:0]  idx;
    logic [7:0]  retries;
    logic        pending;
    logic        int_s1, int_s2, int_s3;
    logic        int_event;
    logic        pend_now;

    function automatic logic [15:0] table_entry(input logic [3:0] i);
        case (i)
            4'd0:    table_entry = 16'h4110;
            4'd1:    table_entry = 16'h9803;
            4'd2:    table_entry = 16'h9AE0;
            4'd3:    table_entry = 16'h9C30;
            4'd4:    table_entry = 16'h9D61;
            4'd5:    table_entry = 16'hA2A4;
            4'd6:    table_entry = 16'hA3A4;
            4'd7:    table_entry = 16'hE0D0;
            4'd8:    table_entry = 16'hF900;
            4'd9:    table_entry = 16'h1500;
            4'd10:   table_entry = 16'h1630;
            4'd11:   table_entry = 16'hAF06;
            default: table_entry = 16'h0000;
        endcase
    endfunction

    // int_s3 holds the previous synchronised level so an assertion edge is a one-cycle event.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            int_s1 <= INT_IDLE;
            int_s2 <= INT_IDLE;
            int_s3 <= INT_IDLE;
        end else begin
            int_s1 <= interrupt;
            int_s2 <= int_s1;
            int_s3 <= int_s2;
        end
    end

    assign int_event   = (int_s2 != INT_IDLE) && (int_s3 == INT_IDLE);
    assign pend_now    = pending | int_event;
    assign wr_dev_addr = DEV_ADDR;
    assign entry_index = idx;
    assign fsm_state   = state;

    // Handshake: wr_req rises with stable reg/data and holds until one wr_ack or wr_nack pulse
    // is sampled in ISSUE; responses arriving in any other state (wr_req low) are ignored.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            state        <= S_WAIT;
            cnt          <= '0;
            idx          <= '0;
            retries      <= '0;
            pending      <= 1'b0;
            wr_req       <= 1'b0;
            wr_reg_addr  <= '0;
            wr_data      <= '0;
            busy         <= 1'b1;
            config_done  <= 1'b0;
            config_error <= 1'b0;
        end else begin
            if (int_event) pending <= 1'b1;
            case (state)
                S_WAIT: begin
                    pending <= 1'b0;
                    if (cnt == WAIT_LAST) begin
                        cnt                    <= '0;
                        idx                    <= '0;
                        retries                <= '0;
                        {wr_reg_addr, wr_data} <= table_entry(4'd0);
                        wr_req                 <= 1'b1;
                        state                  <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_ISSUE: begin
                    if (wr_nack || wr_ack) begin
                        wr_req <= 1'b0;
                        if (pend_now) begin
                            state   <= S_WAIT;
                            cnt     <= '0;
                            pending <= 1'b0;
                        end else if (wr_nack) begin
                            if (retries == RETRY_MAX) begin
                                state        <= S_ERROR;
                                busy         <= 1'b0;
                                config_error <= 1'b1;
                            end else begin
                                retries <= retries + 8'd1;
                                cnt     <= '0;
                                state   <= S_GAP;
                            end
                        end else if (idx == LAST_IDX) begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            config_done <= 1'b1;
                        end else begin
                            idx     <= idx + 4'd1;
                            retries <= '0;
                            state   <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    {wr_reg_addr, wr_data} <= table_entry(idx);
                    wr_req                 <= 1'b1;
                    state                  <= S_ISSUE;
                end
                S_GAP: begin
                    if (pend_now) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        pending <= 1'b0;
                    end else if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        wr_req <= 1'b1;
                        state  <= S_ISSUE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (pend_now) begin
                        state        <= S_WAIT;
                        cnt          <= '0;
                        pending      <= 1'b0;
                        busy         <= 1'b1;
                        config_done  <= 1'b0;
                        config_error <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_WAIT;
                    cnt    <= '0;
                    wr_req <= 1'b0;
                    busy   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_tx_init_sequencer.sv
// Directed bench for hdmi_tx_init_sequencer: acks/nacks writes, restarts via interrupt and reset,
// and checks every issued write against a queue of expected table entries.
module tb_hdmi_tx_init_sequencer;

    logic       clock_25 = 1'b0;
    logic       reset    = 1'b1;
    logic       interrupt = 1'b1;
    logic       wr_ack   = 1'b0;
    logic       wr_nack  = 1'b0;
    logic       wr_req;
    logic [7:0] wr_dev_addr, wr_reg_addr, wr_data;
    logic       busy, config_done, config_error;
    logic [3:0] entry_index;
    logic [2:0] fsm_state;

    int errors = 0;
    int checks = 0;
    int req_count = 0;
    logic req_prev = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] tbl[12] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
                             16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF06};

    hdmi_tx_init_sequencer #(
        .DEV_ADDR(8'h72), .TABLE_LEN(12), .WAIT_CYCLES(10), .RETRY_GAP(4),
        .MAX_RETRIES(3), .INT_ACTIVE_LOW(1'b1)
    ) dut (
        .clock_25(clock_25), .reset(reset), .interrupt(interrupt),
        .wr_req(wr_req), .wr_dev_addr(wr_dev_addr), .wr_reg_addr(wr_reg_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .wr_nack(wr_nack), .busy(busy),
        .config_done(config_done), .config_error(config_error),
        .entry_index(entry_index), .fsm_state(fsm_state)
    );

    // clock / reset block
    always #20 clock_25 = ~clock_25;

    always @(negedge clock_25) begin
        if (wr_req && !req_prev) req_count++;
        req_prev = wr_req;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock_25);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pushes the expected entry, waits for the request, compares, then answers with ack or nack.
    task automatic do_write(input logic [15:0] exp, input bit nack, input int idle_exp);
        int waits;
        logic [15:0] want;
        exp_q.push_back(exp);
        waits = 0;
        while (wr_req !== 1'b1 && waits < 200) begin
            step(1);
            waits++;
        end
        chk("req_seen", {31'd0, wr_req}, 32'd1);
        if (idle_exp >= 0) chk("idle_cycles", waits, idle_exp);
        want = exp_q.pop_front();
        chk("req_entry", {16'd0, wr_reg_addr, wr_data}, {16'd0, want});
        step(4);
        chk("req_hold", {15'd0, wr_req, wr_reg_addr, wr_data}, {15'd0, 1'b1, want});
        if (nack) wr_nack = 1'b1;
        else wr_ack = 1'b1;
        step(1);
        wr_ack  = 1'b0;
        wr_nack = 1'b0;
        chk("req_drop", {31'd0, wr_req}, 32'd0);
    endtask

    // Low interrupt pulse from DONE/ERROR; the flag must clear within 4 cycles, then a 10-cycle wait.
    task automatic int_restart(input bit from_error);
        bit dropped;
        dropped = 1'b0;
        interrupt = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            if (k == 3) interrupt = 1'b1;
            if ((from_error ? config_error : config_done) === 1'b0) begin
                dropped = 1'b1;
                break;
            end
        end
        interrupt = 1'b1;
        chk("flag_drop", {31'd0, dropped}, 32'd1);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        step(9);
        chk("restart_wait", {31'd0, wr_req}, 32'd0);
        do_write(tbl[0], 1'b0, 1);
    endtask

    initial begin
        int base;
        int waits;
        // Test 1: reset state, first request timing, full table
        step(3);
        chk("rst_req", {31'd0, wr_req}, 32'd0);
        chk("rst_regdata", {16'd0, wr_reg_addr, wr_data}, 32'd0);
        chk("rst_flags", {29'd0, busy, config_done, config_error}, 32'b100);
        chk("rst_index", {28'd0, entry_index}, 32'd0);
        chk("dev_addr", {24'd0, wr_dev_addr}, 32'h72);
        reset = 1'b0;
        step(9);
        chk("first_req_early", {31'd0, wr_req}, 32'd0);
        do_write(tbl[0], 1'b0, 1);
        for (int i = 1; i < 12; i++) do_write(tbl[i], 1'b0, 1);
        chk("t1_flags", {29'd0, busy, config_done, config_error}, 32'b010);
        chk("t1_index", {28'd0, entry_index}, 32'd11);

        // Test 4 then test 2: interrupt in DONE, re-run with entry 3 nacked twice
        int_restart(1'b0);
        for (int i = 1; i < 3; i++) do_write(tbl[i], 1'b0, 1);
        do_write(tbl[3], 1'b1, 1);
        do_write(tbl[3], 1'b1, 4);
        do_write(tbl[3], 1'b0, 4);
        for (int i = 4; i < 12; i++) do_write(tbl[i], 1'b0, 1);
        chk("t2_flags", {29'd0, busy, config_done, config_error}, 32'b010);

        // Test 5: interrupt while entry 7 waits for its ack
        int_restart(1'b0);
        for (int i = 1; i < 7; i++) do_write(tbl[i], 1'b0, 1);
        waits = 0;
        while (wr_req !== 1'b1 && waits < 200) begin
            step(1);
            waits++;
        end
        chk("t5_entry7", {16'd0, wr_reg_addr, wr_data}, {16'd0, tbl[7]});
        interrupt = 1'b0;
        step(4);
        interrupt = 1'b1;
        step(2);
        chk("t5_req_held", {31'd0, wr_req}, 32'd1);
        wr_ack = 1'b1;
        step(1);
        wr_ack = 1'b0;
        chk("t5_req_drop", {31'd0, wr_req}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        do_write(tbl[0], 1'b0, 10);

        // Test 3: entry 5 nacked until retries run out
        for (int i = 1; i < 5; i++) do_write(tbl[i], 1'b0, 1);
        base = req_count;
        do_write(tbl[5], 1'b1, 1);
        for (int r = 0; r < 3; r++) do_write(tbl[5], 1'b1, 4);
        chk("t3_flags", {29'd0, busy, config_done, config_error}, 32'b001);
        chk("t3_index", {28'd0, entry_index}, 32'd5);
        step(30);
        chk("t3_req_count", req_count - base, 32'd4);
        chk("t3_no_req", {31'd0, wr_req}, 32'd0);
        chk("t3_sticky", {31'd0, config_error}, 32'd1);

        // Test 6: leave ERROR by interrupt, then reset while entry 4 is requested
        int_restart(1'b1);
        for (int i = 1; i < 4; i++) do_write(tbl[i], 1'b0, 1);
        waits = 0;
        while (wr_req !== 1'b1 && waits < 200) begin
            step(1);
            waits++;
        end
        chk("t6_entry4", {16'd0, wr_reg_addr, wr_data}, {16'd0, tbl[4]});
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_req", {31'd0, wr_req}, 32'd0);
        chk("t6_index", {28'd0, entry_index}, 32'd0);
        chk("t6_flags", {29'd0, busy, config_done, config_error}, 32'b100);
        wr_ack = 1'b1;
        step(1);
        wr_ack = 1'b0;
        chk("t6_stale_ack", {31'd0, wr_req}, 32'd0);
        do_write(tbl[0], 1'b0, 9);
        for (int i = 1; i < 12; i++) do_write(tbl[i], 1'b0, 1);
        chk("t6_flags_end", {29'd0, busy, config_done, config_error}, 32'b010);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
